// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_slave_pkg;

    // Receive/transmit sequencing states
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        HOLD
    } state_e;

    // Command field values carried in the two MSBs of each frame
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int ADDR_SIZE_DEFAULT = 8;
    localparam int FRAME_LEN         = ADDR_SIZE_DEFAULT + 2;

    // Frame word width for a given RAM address/data width
    function automatic int frame_len(input int addr_size);
        return addr_size + 2;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-side rx/tx handshake of the SPI slave.
// Optional macro SPI_SLAVE_FRAME_ERR_EN adds the frame_err abort indicator.
interface spi_slave_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                 frame_err;
`endif

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
        output frame_err,
`endif
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
        input  frame_err,
`endif
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first shift register for the read byte.
// Holds the WIDTH-1 bits that follow the MSB (the MSB is driven at load time).
module spi_tx_shifter
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = ADDR_SIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-2:0] load_data,
    output logic             sout,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-2:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Next-state: clear beats load beats shift
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (load) begin
            sreg_d = load_data;
            cnt_d  = CW'(WIDTH - 1);
        end else if (shift && cnt_q != '0) begin
            sreg_d = {sreg_q[WIDTH-3:0], 1'b0};
            cnt_d  = cnt_q - CW'(1);
        end
    end

    // Shift register and remaining-bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sout = sreg_q[WIDTH-2];
    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/spi_slave.sv
// SPI slave: deserialises MOSI frames to rx_data/rx_valid and serialises
// the RAM read byte on MISO. Optional macro SPI_SLAVE_FRAME_ERR_EN adds
// a frame_err pulse on SS_n aborts.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
) (
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);
    localparam int FW = frame_len(ADDR_SIZE);
    localparam int CW = $clog2(ADDR_SIZE + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FW-2:0]   rx_shift_q, rx_shift_d;
    logic [FW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            miso_q, miso_d;
    logic            rd_addr_done_q, rd_addr_done_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic            frame_err_q, frame_err_d;
`endif

    logic            tx_load, tx_shift, tx_clear;
    logic            tx_bit, tx_done;

    spi_tx_shifter #(
        .WIDTH (ADDR_SIZE)
    ) u_tx_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tx_clear),
        .load      (tx_load),
        .shift     (tx_shift),
        .load_data (bus.tx_data[ADDR_SIZE-2:0]),
        .sout      (tx_bit),
        .done      (tx_done)
    );

    // Next-state and output decode; an SS_n abort overrides every state
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        tx_load        = 1'b0;
        tx_shift       = 1'b0;
        tx_clear       = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d    = 1'b0;
`endif
        if (state_q != IDLE && bus.SS_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_clear  = 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_d = (state_q != HOLD);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.SS_n) state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    rx_shift_d = {{(FW-2){1'b0}}, bus.MOSI};
                    bit_cnt_d  = CW'(ADDR_SIZE);
                    if (!bus.MOSI)          state_d = WRITE;
                    else if (rd_addr_done_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt_q == '0) begin
                        rx_data_d  = {rx_shift_q, bus.MOSI};
                        rx_valid_d = 1'b1;
                        if (state_q == READ_DATA) begin
                            state_d = TX_WAIT;
                        end else begin
                            state_d = HOLD;
                            if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
                        end
                    end else begin
                        rx_shift_d = {rx_shift_q[FW-3:0], bus.MOSI};
                        bit_cnt_d  = bit_cnt_q - CW'(1);
                    end
                end
                TX_WAIT: begin
                    if (bus.tx_valid) begin
                        tx_load = 1'b1;
                        miso_d  = bus.tx_data[ADDR_SIZE-1];
                        state_d = TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    tx_shift = 1'b1;
                    miso_d   = tx_bit;
                    if (tx_done) begin
                        rd_addr_done_d = 1'b0;
                        state_d        = HOLD;
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_done_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_done_q <= rd_addr_done_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q    <= frame_err_d;
`endif
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign bus.frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: table of frames with expected MISO/rx behaviour,
// rx_data scoreboard, plus an asynchronous-reset sequence during TX_SHIFT.
module tb_spi_slave;
    import spi_slave_pkg::*;

    logic clk;
    logic rst_n;

    spi_slave_if #(.ADDR_SIZE(8)) sif ();

    spi_slave #(
        .ADDR_SIZE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];

    typedef struct {
        string      name;
        logic [9:0] frame;
        logic [7:0] ram;
        bit         exp_tx;
        bit         early;
        int         abort_edge;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [9:0] f, input logic [7:0] r,
                                input bit tx, input bit early, input int ab);
        vec_t v;
        v.name = n; v.frame = f; v.ram = r; v.exp_tx = tx; v.early = early; v.abort_edge = ab;
        return v;
    endfunction

    // Scoreboard: every rx_valid pulse must match the oldest expected word
    always @(negedge clk) begin : rx_monitor
        logic [9:0] want;
        if (rst_n && sif.rx_valid) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 32'(sif.rx_data), 32'h0);
                if (sif.rx_data == '0) begin
                    failures++;
                    $display("FAIL rx_unexpected actual=pulse required=none");
                end
            end else begin
                want = exp_q.pop_front();
                check("rx_data", 32'(sif.rx_data), 32'(want));
            end
        end
    end

    // One frame from SS_n low through return to IDLE; edge e counts rising edges
    task automatic run_frame(input vec_t v);
        int   ld;
        bit   rx_ok;
        logic exp_bit;
        ld    = v.early ? 12 : 13;
        rx_ok = (v.abort_edge == 0) || (v.abort_edge > 11);
        if (rx_ok) exp_q.push_back(v.frame);
        sif.SS_n = 1'b0;
        sif.MOSI = v.frame[9];
        if (v.early) begin
            sif.tx_data  = v.ram;
            sif.tx_valid = 1'b1;
        end
        for (int e = 1; e <= 23; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s/rx_valid@e%0d", v.name, e), 32'(sif.rx_valid), 32'(rx_ok && e == 11));
            exp_bit = 1'b0;
            if (v.exp_tx && e >= ld && e < ld + 8 && (v.abort_edge == 0 || e < v.abort_edge))
                exp_bit = v.ram[7 - (e - ld)];
            check($sformatf("%s/miso@e%0d", v.name, e), 32'(sif.MISO), 32'(exp_bit));
`ifdef SPI_SLAVE_FRAME_ERR_EN
            check($sformatf("%s/frame_err@e%0d", v.name, e), 32'(sif.frame_err), 32'(e == v.abort_edge));
`endif
            if (e <= 10) sif.MOSI = v.frame[10 - e];
            else         sif.MOSI = 1'b1;
            if (e == 12 && !v.early && v.frame[9:8] == CMD_RD_DATA) begin
                sif.tx_data  = v.ram;
                sif.tx_valid = 1'b1;
            end
            if (e == 13) sif.tx_valid = 1'b0;
            if (v.abort_edge != 0 && e == v.abort_edge - 1) sif.SS_n = 1'b1;
            if (e == 21) sif.SS_n = 1'b1;
        end
    endtask

    initial begin : main
        logic [9:0] fr;
        rst_n        = 1'b0;
        sif.SS_n     = 1'b1;
        sif.MOSI     = 1'b0;
        sif.tx_data  = '0;
        sif.tx_valid = 1'b0;

        vecs[0]  = mk("rd_first_after_reset", 10'h3C3, 8'hFF, 1'b0, 1'b0, 0);
        vecs[1]  = mk("wr_addr",              10'h0A5, 8'h00, 1'b0, 1'b0, 0);
        vecs[2]  = mk("wr_data",              10'h13C, 8'h00, 1'b0, 1'b0, 0);
        vecs[3]  = mk("rd_data_c3",           10'h300, 8'hC3, 1'b1, 1'b0, 0);
        vecs[4]  = mk("rd_addr",              10'h2A5, 8'h00, 1'b0, 1'b0, 0);
        vecs[5]  = mk("rd_data_early_valid",  10'h3A5, 8'h96, 1'b1, 1'b1, 0);
        vecs[6]  = mk("wr_abort_5bits",       10'h0F0, 8'h00, 1'b0, 1'b0, 7);
        vecs[7]  = mk("wr_abort_last_bit",    10'h1FF, 8'h00, 1'b0, 1'b0, 11);
        vecs[8]  = mk("rd_addr_2",            10'h25A, 8'h00, 1'b0, 1'b0, 0);
        vecs[9]  = mk("rd_abort_tx_shift",    10'h300, 8'hA5, 1'b1, 1'b0, 16);
        vecs[10] = mk("rd_retry",             10'h300, 8'hA5, 1'b1, 1'b0, 0);
        vecs[11] = mk("rd_after_clear",       10'h3FF, 8'h3C, 1'b0, 1'b0, 0);
        vecs[12] = mk("rd_abort_tx_wait",     10'h311, 8'h81, 1'b1, 1'b0, 13);
        vecs[13] = mk("rd_retry_2",           10'h311, 8'h81, 1'b1, 1'b0, 0);

        repeat (2) @(negedge clk);
        check("reset/miso",     32'(sif.MISO),     32'h0);
        check("reset/rx_valid", 32'(sif.rx_valid), 32'h0);
        check("reset/rx_data",  32'(sif.rx_data),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset/state", 32'(dut.state_q), 32'(IDLE));

        for (int i = 0; i < NV; i++) run_frame(vecs[i]);

        // Set the read address, then reset asynchronously mid TX_SHIFT
        run_frame(mk("rd_addr_pre_reset", 10'h2C0, 8'h00, 1'b0, 1'b0, 0));
        fr = 10'h300;
        exp_q.push_back(fr);
        sif.SS_n = 1'b0;
        sif.MOSI = fr[9];
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e <= 10) sif.MOSI = fr[10 - e];
            if (e == 12) begin
                sif.tx_data  = 8'hC3;
                sif.tx_valid = 1'b1;
            end
            if (e == 13) sif.tx_valid = 1'b0;
        end
        check("pre_reset/miso_bit6", 32'(sif.MISO), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset/miso",         32'(sif.MISO),           32'h0);
        check("async_reset/rx_data",      32'(sif.rx_data),        32'h0);
        check("async_reset/state",        32'(dut.state_q),        32'(IDLE));
        check("async_reset/rd_addr_done", 32'(dut.rd_addr_done_q), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        sif.SS_n = 1'b1;
        sif.MOSI = 1'b0;
        @(negedge clk);
        check("post_reset/miso", 32'(sif.MISO), 32'h0);

        // rd_addr_done was cleared by reset: MSB=1 frame must not transmit
        run_frame(mk("rd_after_async_reset", 10'h3C3, 8'hFF, 1'b0, 1'b0, 0));

        repeat (3) @(negedge clk);
        check("scoreboard/pending", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
